regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back arbiter for the 32x32 register file's single write port. Two producers (ALU result path, memory load path) present writes over valid/ready handshakes. Each producer has a one-entry holding buffer, and buffered writes are granted round-robin onto a registered wr_en/wr_addr/wr_data bus that drives the register file directly. Writes to R0 are filtered and counted. A pending-register mask is exported so the decode stage can stall on in-flight destinations.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register address width; register count = 2**ADDR_W
CNT_W, 8, width of saturating R0-drop counter

Ports:
elk  input  1  clock; all state updates on posedge elk
nrst  input  1  reset, synchronous, active-high
alu_valid  input  1  ALU write request
alu_ready  output  1  ALU request accepted this cycle when valid&&ready
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load write request
mem_ready  output  1  load request accepted when valid&&ready
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
wr_en  output  1  register-file write enable (registered)
wr_addr  output  ADDR_W  register-file write address (registered)
wr_data  output  DATA_W  register-file write data (registered)
pend_mask  output  2**ADDR_W  bit i=1: write to Ri buffered or on wr_* bus
drop_cnt  output  CNT_W  count of discarded R0 write requests

Behaviour:
- Reset (nrst=1 at posedge elk): both buffers empty, wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0, rr_last=MEM (ALU wins first contention), age flags cleared. While nrst=1, alu_ready=mem_ready=0. Reset mid-operation discards buffered writes; no write is emitted for them.
- Buffers: hold_alu and hold_mem each store {addr, data, full, age}.
- Ready: x_ready = !nrst && (!x_full || grant_x), combinational from current state. Back-to-back acceptance at one write per cycle per producer is allowed when that producer is granted every cycle.
- Accept: on valid&&ready with addr!=0, the buffer loads at the edge. With addr==0, the handshake completes, the buffer is not loaded, and drop_cnt increments. A same-cycle R0 accept on both ports adds 2. drop_cnt saturates at 2**CNT_W-1.
- Arbitration (combinational, from buffer state at the start of the cycle):
  - One full buffer: grant it.
  - Both full with different addrs: grant the side != rr_last.
  - Both full with the same addr: grant the older entry (age flag). If both were loaded on the same edge, grant MEM first.
  - rr_last updates to the granted side.
- Output: at the edge following a grant, wr_en=1 and wr_addr/wr_data = granted entry, and that buffer clears (or reloads if a new accept happens on the same edge). With no grant, wr_en=0 and wr_addr/wr_data hold their previous values.
- Latency: accept at edge N; wr_en high during the cycle after edge N+1 at the earliest; register file captures at edge N+2. Worst case under continuous contention: one extra cycle.
- Throughput: one register-file write per cycle max. Under sustained dual traffic, each producer gets one accept every 2 cycles.
- pend_mask: OR of one-hot(addr) over the full buffers and one-hot(wr_addr) when wr_en=1. Bit 0 is always 0.
- wr_addr is never 0 while wr_en=1.

Test Plan:
1. Reset: hold nrst=1 for 2 cycles with both valids high -> readys 0, wr_en=0, pend_mask=0, drop_cnt=0. Release -> first accept on the next edge.
2. Single ALU write addr=5, data=0xDEADBEEF, accept at edge N -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF after edge N+1. pend_mask[5]=1 from edge N until wr_en drops.
3. Simultaneous ALU addr=3 / MEM addr=4 after reset -> ALU written first (wr_addr=3), MEM next cycle (wr_addr=4). A further contention pair -> MEM first.
4. Same-cycle ALU addr=7 data=1 and MEM addr=7 data=2 -> MEM written first, then ALU. R7 final value = 1.
5. R0 filter: 300 ALU writes to addr=0 -> wr_en never 1, drop_cnt=255. One cycle with both ports at addr 0 and drop_cnt=10 -> 12.
6. Sustained traffic, both valids held high with distinct addrs for 20 cycles -> wr_en=1 every cycle after the first, grants alternate, each ready pulses every other cycle. Assert nrst mid-stream -> next cycle wr_en=0, pend_mask=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter for the register file's single write port
//
// Two producers (ALU, memory load) each hand writes over a valid/ready
// handshake into a one-entry holding buffer. Buffered writes are granted onto
// a registered write bus. Writes to R0 are dropped and counted.
//
// Ports:
//   elk, nrst                      clock, synchronous active-high reset
//   alu_valid/ready/addr/data      ALU result write request
//   mem_valid/ready/addr/data      load write request
//   wr_en/wr_addr/wr_data          registered register-file write port
//   pend_mask                      one bit per register with a write in flight
//   drop_cnt                       saturating count of discarded R0 writes
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic                     elk,
    input  logic                     nrst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_W-1:0]        alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [(1<<ADDR_W)-1:0]   pend_mask,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam logic RR_ALU = 1'b0;
    localparam logic RR_MEM = 1'b1;

    logic              alu_full_q, alu_full_d, alu_age_q, alu_age_d;
    logic [ADDR_W-1:0] alu_addr_q, alu_addr_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d;
    logic              mem_full_q, mem_full_d, mem_age_q, mem_age_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              rr_last_q, rr_last_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic both_full, grant_alu, grant_mem;
    logic alu_acc, mem_acc, alu_load, mem_load, alu_drop, mem_drop;
    logic [CNT_W:0] drop_sum;

    // Age flag marks the entry that has waited longer than the other one.
    // It only matters when both buffers target the same register, where the
    // older write must land first so the newer value survives.
    always_comb begin
        both_full = alu_full_q && mem_full_q;
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (both_full) begin
            if (alu_addr_q == mem_addr_q) begin
                grant_alu = alu_age_q;
            end else begin
                grant_alu = (rr_last_q == RR_MEM);
            end
            grant_mem = !grant_alu;
        end else begin
            grant_alu = alu_full_q;
            grant_mem = mem_full_q;
        end
    end

    // A granted buffer frees up at this edge, so it can take a new entry now.
    assign alu_ready = !nrst && (!alu_full_q || grant_alu);
    assign mem_ready = !nrst && (!mem_full_q || grant_mem);

    assign alu_acc  = alu_valid && alu_ready;
    assign mem_acc  = mem_valid && mem_ready;
    assign alu_load = alu_acc && (alu_addr != '0);
    assign mem_load = mem_acc && (mem_addr != '0);
    assign alu_drop = alu_acc && (alu_addr == '0);
    assign mem_drop = mem_acc && (mem_addr == '0);

    always_comb begin
        alu_full_d = alu_full_q;
        alu_age_d  = alu_age_q;
        alu_addr_d = alu_addr_q;
        alu_data_d = alu_data_q;
        mem_full_d = mem_full_q;
        mem_age_d  = mem_age_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rr_last_d  = rr_last_q;
        wr_en_d    = grant_alu || grant_mem;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (grant_alu) begin
            wr_addr_d = alu_addr_q;
            wr_data_d = alu_data_q;
        end else if (grant_mem) begin
            wr_addr_d = mem_addr_q;
            wr_data_d = mem_data_q;
        end

        // Round-robin pointer only moves when there was real contention.
        if (both_full) begin
            rr_last_d = grant_mem ? RR_MEM : RR_ALU;
        end

        if (alu_load) begin
            alu_full_d = 1'b1;
            alu_age_d  = 1'b0;
            alu_addr_d = alu_addr;
            alu_data_d = alu_data;
        end else if (grant_alu) begin
            alu_full_d = 1'b0;
            alu_age_d  = 1'b0;
        end else if (alu_full_q && mem_load) begin
            alu_age_d = 1'b1;
        end

        if (mem_load) begin
            mem_full_d = 1'b1;
            mem_age_d  = 1'b0;
            mem_addr_d = mem_addr;
            mem_data_d = mem_data;
        end else if (grant_mem) begin
            mem_full_d = 1'b0;
            mem_age_d  = 1'b0;
        end else if (mem_full_q && alu_load) begin
            mem_age_d = 1'b1;
        end

        drop_sum = {1'b0, drop_cnt_q} + {{CNT_W{1'b0}}, alu_drop}
                 + {{CNT_W{1'b0}}, mem_drop};
        drop_cnt_d = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge elk) begin
        if (nrst) begin
            alu_full_q <= 1'b0;
            alu_age_q  <= 1'b0;
            alu_addr_q <= '0;
            alu_data_q <= '0;
            mem_full_q <= 1'b0;
            mem_age_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rr_last_q  <= RR_MEM;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            alu_full_q <= alu_full_d;
            alu_age_q  <= alu_age_d;
            alu_addr_q <= alu_addr_d;
            alu_data_q <= alu_data_d;
            mem_full_q <= mem_full_d;
            mem_age_q  <= mem_age_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rr_last_q  <= rr_last_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        if (alu_full_q) pend_mask[alu_addr_q] = 1'b1;
        if (mem_full_q) pend_mask[mem_addr_q] = 1'b1;
        if (wr_en_q)    pend_mask[wr_addr_q]  = 1'b1;
        pend_mask[0] = 1'b0;
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        elk = 1'b0;
    logic        nrst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_addr = '0, mem_addr = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, pend_mask;
    logic [7:0]  drop_cnt;

    always #5 elk = ~elk;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(8)) dut (
        .elk(elk), .nrst(nrst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_mask(pend_mask), .drop_cnt(drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each producer slot holds an entry tagged with the
    // edge number it arrived on; older tag wins a same-register conflict.
    bit          m_full[2];
    logic [4:0]  m_addr[2];
    logic [31:0] m_data[2];
    int          m_seq[2];
    int          seq_ctr = 0;
    int          m_rr = 1;
    logic        m_wr_en = 1'b0;
    logic [4:0]  m_wr_addr = '0;
    logic [31:0] m_wr_data = '0;
    int          m_drop = 0;
    logic [31:0] m_rf[32];
    logic [31:0] d_rf[32];

    function automatic int m_grant();
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
            return 1 - m_rr;
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(int s);
        return !nrst && (!m_full[s] || m_grant() == s);
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int s = 0; s < 2; s++) if (m_full[s]) p[m_addr[s]] = 1'b1;
        if (m_wr_en) p[m_wr_addr] = 1'b1;
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int g;
        bit both, acc0, acc1;
        if (nrst) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
            m_drop = 0; m_rr = 1;
            return;
        end
        g    = m_grant();
        both = m_full[0] && m_full[1];
        acc0 = alu_valid && m_ready(0);
        acc1 = mem_valid && m_ready(1);
        if (g >= 0) begin
            m_wr_en = 1'b1;
            m_wr_addr = m_addr[g];
            m_wr_data = m_data[g];
            m_rf[m_addr[g]] = m_data[g];
            m_full[g] = 0;
            if (both) m_rr = g;
        end else begin
            m_wr_en = 1'b0;
        end
        seq_ctr++;
        if (acc0) begin
            if (alu_addr == 5'd0) m_drop++;
            else begin m_full[0] = 1; m_addr[0] = alu_addr; m_data[0] = alu_data; m_seq[0] = seq_ctr; end
        end
        if (acc1) begin
            if (mem_addr == 5'd0) m_drop++;
            else begin m_full[1] = 1; m_addr[1] = mem_addr; m_data[1] = mem_data; m_seq[1] = seq_ctr; end
        end
        if (m_drop > 255) m_drop = 255;
    endtask

    // Called at the negedge: compare everything, then run through the edge.
    task automatic finish_cycle();
        check("model", {alu_ready, mem_ready, wr_en, wr_addr, wr_data, pend_mask, drop_cnt},
              {m_ready(0), m_ready(1), m_wr_en, m_wr_addr, m_wr_data, m_pend(), 8'(m_drop)});
        if (wr_en === 1'b1) d_rf[wr_addr] = wr_data;
        @(posedge elk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        @(negedge elk);
        finish_cycle();
    endtask

    task automatic set_in(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic mv, input logic [4:0] ma, input logic [31:0] md);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
    endtask

    typedef struct {
        logic        rst, av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_ar, e_mr, e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd, e_pend;
    } vec_t;

    vec_t tbl[13];
    int   wr_cnt, a_acc, m_acc;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0};
        tbl[1]  = '{1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0};
        tbl[2]  = '{1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,  32'h0};
        tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  32'h18};
        tbl[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 32'h18};
        tbl[5]  = '{1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44, 32'h10};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd4, 32'h44, 32'h300};
        tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 32'h300};
        tbl[8]  = '{1'b0, 1'b1, 5'd7, 32'h1,  1'b1, 5'd7, 32'h2,  1'b1, 1'b1, 1'b1, 5'd8, 32'h88, 32'h100};
        tbl[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd8, 32'h88, 32'h80};
        tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7, 32'h2,  32'h80};
        tbl[11] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b1, 5'd7, 32'h1,  32'h80};
        tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 1'b0, 5'd7, 32'h1,  32'h0};
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; d_rf[r] = '0; end

        // Bring the DUT out of its unknown power-up state.
        nrst = 1'b1;
        @(posedge elk);
        model_step();
        #1;

        // Reset hold, first accept, round-robin order, same-register ordering.
        for (int i = 0; i < 13; i++) begin
            nrst = tbl[i].rst;
            set_in(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md);
            @(negedge elk);
            check($sformatf("vec%0d", i),
                  {alu_ready, mem_ready, wr_en, wr_addr, wr_data, pend_mask, drop_cnt},
                  {tbl[i].e_ar, tbl[i].e_mr, tbl[i].e_we, tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_pend, 8'd0});
            finish_cycle();
        end
        check("r7_final", d_rf[7], 32'h1);

        // Single ALU write, latency and pending bit.
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        cycle();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge elk);
        check("lat_n1", {wr_en, pend_mask[5]}, {1'b0, 1'b1});
        finish_cycle();
        @(negedge elk);
        check("lat_n2", {wr_en, wr_addr, wr_data, pend_mask[5]}, {1'b1, 5'd5, 32'hDEADBEEF, 1'b1});
        finish_cycle();
        @(negedge elk);
        check("lat_n3", {wr_en, pend_mask[5]}, {1'b0, 1'b0});
        finish_cycle();

        // R0 filter and drop counter saturation.
        nrst = 1'b1; cycle(); nrst = 1'b0;
        wr_cnt = 0;
        set_in(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 300; i++) begin
            @(negedge elk);
            if (wr_en === 1'b1) wr_cnt++;
            finish_cycle();
        end
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge elk);
        check("r0_sat", {wr_en, drop_cnt}, {1'b0, 8'd255});
        check("r0_nowr", wr_cnt, 0);
        finish_cycle();

        nrst = 1'b1; cycle(); nrst = 1'b0;
        set_in(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (10) cycle();
        set_in(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
        @(negedge elk);
        check("r0_ten", drop_cnt, 8'd10);
        finish_cycle();
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge elk);
        check("r0_dual", drop_cnt, 8'd12);
        finish_cycle();

        // Sustained dual traffic, then reset mid-stream.
        nrst = 1'b1; cycle(); nrst = 1'b0;
        wr_cnt = 0; a_acc = 0; m_acc = 0;
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 5'(1 + i % 15), $urandom, 1'b1, 5'(16 + i % 15), $urandom);
            @(negedge elk);
            if (i >= 2 && wr_en === 1'b1) wr_cnt++;
            if (alu_ready === 1'b1) a_acc++;
            if (mem_ready === 1'b1) m_acc++;
            finish_cycle();
        end
        check("sus_wr", wr_cnt, 18);
        check("sus_alu", a_acc, 11);
        check("sus_mem", m_acc, 10);
        nrst = 1'b1; cycle();
        nrst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge elk);
        check("mid_rst", {wr_en, pend_mask}, {1'b0, 32'h0});
        finish_cycle();

        // Randomized traffic with narrow address range to force conflicts.
        for (int i = 0; i < 3000; i++) begin
            nrst = ($urandom_range(0, 199) == 0);
            set_in(1'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                   $urandom,
                   1'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                   $urandom);
            cycle();
        end
        nrst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (4) cycle();
        for (int r = 1; r < 32; r++) check($sformatf("rf%0d", r), d_rf[r], m_rf[r]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
